data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage and a DMA/debug master.
//  Sequences multi-cycle accesses (ACCESS_CYCLES per access) and stalls the pipeline while its access is pending.
//  Drives the memory's read/write/address/data controls.
//  Sits between the MEM stage and DataMem. DataMem read data is combinational from its address.
// PARAMETERS
//  ADDR_W         32  address width
//  DATA_W         32  data width
//  ACCESS_CYCLES  3   cycles per memory access, >=1; counted from the grant cycle inclusive
//  STARVE_LIMIT   2   max consecutive pipe grants while dmaReq pending; 0 = DMA strict priority
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset
//  pipeRead   in   1       MEM stage load request (level, held while pipeStall=1)
//  pipeWrite  in   1       MEM stage store request (level, held while pipeStall=1)
//  pipeAddr   in   ADDR_W  MEM stage address
//  pipeData   in   DATA_W  MEM stage store data
//  pipeStall  out  1       freeze pipeline registers upstream of and including EX/MEM
//  pipeOut    out  DATA_W  load data to MEM/WB register
//  dmaReq     in   1       DMA request (level, held until dmaAck)
//  dmaWe      in   1       1 = DMA write, 0 = DMA read
//  dmaAddr    in   ADDR_W  DMA address
//  dmaData    in   DATA_W  DMA write data
//  dmaAck     out  1       one-cycle completion pulse
//  dmaOut     out  DATA_W  DMA read data, valid while dmaAck=1 and held after
//  memRead    out  1       to DataMem
//  memWrite   out  1       to DataMem
//  memAddr    out  ADDR_W  to DataMem
//  memData    out  DATA_W  write data to DataMem
//  memOut     in   DATA_W  read data from DataMem
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; cnt=0; starveCnt=0; dmaAck=0; dmaOut=0; pipeOut=0 (held reg).
//    memRead=memWrite=0 combinationally during reset. An in-flight access is dropped; no write is issued.
//  States:
//    IDLE: no access in flight; the grant is decided combinationally this cycle.
//    PIPE: pipe access in flight, cnt counts remaining cycles.
//    DMA:  DMA access in flight, cnt counts remaining cycles.
//  Grant in IDLE:
//    pipeReq = pipeRead|pipeWrite; dmaElig = dmaReq & ~dmaAck.
//    DMA wins if dmaElig & (starveCnt==STARVE_LIMIT | ~pipeReq). Otherwise pipe wins if pipeReq.
//  Access timing:
//    The grant cycle is access cycle 1. The last cycle of an access is its done cycle.
//    If ACCESS_CYCLES==1, the done cycle is the grant cycle and the state stays IDLE.
//    Otherwise: next state PIPE/DMA, cnt=ACCESS_CYCLES-2; decrement each cycle; done when cnt==0; then -> IDLE.
//    Every completion returns to IDLE, so any requester's next access is granted the following cycle.
//  Memory drive:
//    memAddr and memData are muxed from the granted source for all cycles of the access.
//    memRead=1 for every cycle of a read access.
//    memWrite=1 only in the done cycle of a write access: exactly one write per access.
//    With no access: memRead=memWrite=0; memAddr and memData hold the pipe values.
//  Pipe:
//    pipeStall = pipeReq & ~(pipe access done this cycle), combinational.
//    pipeOut = memOut in the pipe read done cycle; otherwise the value captured at the last pipe read done edge.
//    pipeRead&pipeWrite together is treated as a write; the read is ignored.
//  DMA:
//    dmaOut is captured from memOut at the DMA read done edge. dmaAck is registered: 1 in the cycle after done.
//    If dmaReq drops mid-access, the access still completes and is acked.
//  Starvation (starveCnt, saturating at STARVE_LIMIT):
//    +1 on each pipe grant while dmaReq=1.
//    Cleared on DMA grant or whenever dmaReq=0.
//  A new requester arriving mid-access waits; in-flight accesses are never pre-empted.
//  Address/data width: pass-through, no arithmetic. Address wrap is DataMem's concern.
// TESTING (ACCESS_CYCLES=3, STARVE_LIMIT=2 unless stated)
//  1. Reset: pulse rst low during cycle 2 of a DMA write to 0x40.
//     -> memWrite never 1, mem[0x40] unchanged, dmaAck=0, state IDLE after release.
//  2. Pipe load: pipeRead addr 0x10, mem[0x10]=0xDEADBEEF.
//     -> pipeStall=1,1,0 over cycles 1-3; pipeOut=0xDEADBEEF in cycle 3 and held.
//  3. Pipe store: pipeWrite 0x20/0x00001234.
//     -> memWrite high exactly cycle 3.
//     -> A following DMA read of 0x20 gives dmaOut=0x00001234 with a 1-cycle dmaAck.
//  4. Starvation: back-to-back pipe loads plus dmaReq held.
//     -> DMA granted after 2 pipe grants; dmaAck 1 cycle; then starveCnt=0.
//  5. ACCESS_CYCLES=1 build: 4 consecutive pipe loads -> pipeStall never 1; each pipeOut is correct.
//  6. pipeRead&pipeWrite both 1 -> write performed.
//     dmaReq dropped in cycle 2 of a DMA read -> read completes, dmaAck still pulses once.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the MEM stage / DMA requesters, the data-memory arbiter and DataMem.
// slave is the arbiter's view; master is the requester and memory side.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              pipeRead;
  logic              pipeWrite;
  logic [ADDR_W-1:0] pipeAddr;
  logic [DATA_W-1:0] pipeData;
  logic              pipeStall;
  logic [DATA_W-1:0] pipeOut;
  logic              dmaReq;
  logic              dmaWe;
  logic [ADDR_W-1:0] dmaAddr;
  logic [DATA_W-1:0] dmaData;
  logic              dmaAck;
  logic [DATA_W-1:0] dmaOut;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] memOut;

  modport slave (
    input  pipeRead, pipeWrite, pipeAddr, pipeData,
    input  dmaReq, dmaWe, dmaAddr, dmaData,
    input  memOut,
    output pipeStall, pipeOut, dmaAck, dmaOut,
    output memRead, memWrite, memAddr, memData
  );

  modport master (
    output pipeRead, pipeWrite, pipeAddr, pipeData,
    output dmaReq, dmaWe, dmaAddr, dmaData,
    output memOut,
    input  pipeStall, pipeOut, dmaAck, dmaOut,
    input  memRead, memWrite, memAddr, memData
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a DMA/debug master,
// sequencing ACCESS_CYCLES-long accesses and stalling the pipeline while its access is pending.
module data_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 3,
  parameter int STARVE_LIMIT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PIPE = 2'd1;
  localparam logic [1:0] ST_DMA  = 2'd2;

  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES - 1) : 1;
  localparam int SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = (ACCESS_CYCLES > 1) ? CNT_W'(ACCESS_CYCLES - 2) : '0;
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SW-1:0]     r_starve;
  logic              r_dma_ack;
  logic [DATA_W-1:0] r_dma_out;
  logic [DATA_W-1:0] r_pipe_out;
  logic              r_dma_we;
  logic [ADDR_W-1:0] r_dma_addr;
  logic [DATA_W-1:0] r_dma_data;

  logic              w_idle;
  logic              w_pipe_req;
  logic              w_dma_elig;
  logic              w_grant_dma;
  logic              w_grant_pipe;
  logic              w_act_pipe;
  logic              w_act_dma;
  logic              w_last;
  logic              w_done_pipe;
  logic              w_done_dma;
  logic              w_dma_we;
  logic [ADDR_W-1:0] w_dma_addr;
  logic [DATA_W-1:0] w_dma_data;

  always_comb begin
    w_idle       = rst && (r_state == ST_IDLE);
    w_pipe_req   = bus.pipeRead | bus.pipeWrite;
    w_dma_elig   = bus.dmaReq & ~r_dma_ack;
    w_grant_dma  = w_idle & w_dma_elig & ((r_starve == STARVE_MAX) | ~w_pipe_req);
    w_grant_pipe = w_idle & ~w_grant_dma & w_pipe_req;
    w_act_pipe   = w_grant_pipe | (rst && (r_state == ST_PIPE));
    w_act_dma    = w_grant_dma  | (rst && (r_state == ST_DMA));
    if (ACCESS_CYCLES == 1) w_last = 1'b1;
    else                    w_last = (r_state != ST_IDLE) && (r_cnt == '0);
    w_done_pipe  = w_act_pipe & w_last;
    w_done_dma   = w_act_dma & w_last;
    // DMA controls are latched at grant so a dropped dmaReq cannot disturb the access
    w_dma_we     = (r_state == ST_IDLE) ? bus.dmaWe   : r_dma_we;
    w_dma_addr   = (r_state == ST_IDLE) ? bus.dmaAddr : r_dma_addr;
    w_dma_data   = (r_state == ST_IDLE) ? bus.dmaData : r_dma_data;
  end

  always_comb begin
    bus.memRead   = (w_act_pipe & ~bus.pipeWrite) | (w_act_dma & ~w_dma_we);
    bus.memWrite  = (w_done_pipe & bus.pipeWrite) | (w_done_dma & w_dma_we);
    bus.memAddr   = w_act_dma ? w_dma_addr : bus.pipeAddr;
    bus.memData   = w_act_dma ? w_dma_data : bus.pipeData;
    bus.pipeStall = w_pipe_req & ~w_done_pipe;
    bus.pipeOut   = (w_done_pipe & ~bus.pipeWrite) ? bus.memOut : r_pipe_out;
    bus.dmaAck    = r_dma_ack;
    bus.dmaOut    = r_dma_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_dma_ack  <= 1'b0;
      r_dma_out  <= '0;
      r_pipe_out <= '0;
    end else begin
      r_dma_ack <= w_done_dma;
      if (w_done_dma & ~w_dma_we)       r_dma_out  <= bus.memOut;
      if (w_done_pipe & ~bus.pipeWrite) r_pipe_out <= bus.memOut;
      if (!bus.dmaReq || w_grant_dma)
        r_starve <= '0;
      else if (w_grant_pipe && (r_starve != STARVE_MAX))
        r_starve <= r_starve + 1'b1;
      if (ACCESS_CYCLES > 1) begin
        case (r_state)
          ST_IDLE: begin
            if (w_grant_dma) begin
              r_state <= ST_DMA;
              r_cnt   <= CNT_LOAD;
            end else if (w_grant_pipe) begin
              r_state <= ST_PIPE;
              r_cnt   <= CNT_LOAD;
            end
          end
          default: begin
            if (r_cnt == '0) r_state <= ST_IDLE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant_dma) begin
      r_dma_we   <= bus.dmaWe;
      r_dma_addr <= bus.dmaAddr;
      r_dma_data <= bus.dmaData;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a 3-cycle build and a 1-cycle build, each on its own memory model.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3), .STARVE_LIMIT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(1), .STARVE_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  logic [31:0] memA [256];
  logic [31:0] memB [256];
  logic        ld_a = 1'b0;
  logic        ld_b = 1'b0;
  logic [7:0]  ld_addr = 8'h00;
  logic [31:0] ld_data = 32'h0;
  int          wr_a = 0;

  assign ifa.memOut = memA[ifa.memAddr[7:0]];
  assign ifb.memOut = memB[ifb.memAddr[7:0]];

  always @(posedge clk) begin
    if (ld_a) memA[ld_addr] <= ld_data;
    if (ld_b) memB[ld_addr] <= ld_data;
    if (ifa.memWrite) begin
      memA[ifa.memAddr[7:0]] <= ifa.memData;
      wr_a <= wr_a + 1;
    end
    if (ifb.memWrite) memB[ifb.memAddr[7:0]] <= ifb.memData;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic load(input logic to_a, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_a = to_a;
    ld_b = ~to_a;
    ld_addr = a;
    ld_data = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ifa.pipeRead = 0; ifa.pipeWrite = 0; ifa.pipeAddr = 0; ifa.pipeData = 0;
    ifa.dmaReq = 0; ifa.dmaWe = 0; ifa.dmaAddr = 0; ifa.dmaData = 0;
    ifb.pipeRead = 0; ifb.pipeWrite = 0; ifb.pipeAddr = 0; ifb.pipeData = 0;
    ifb.dmaReq = 0; ifb.dmaWe = 0; ifb.dmaAddr = 0; ifb.dmaData = 0;

    // Preload memories while held in reset
    load(1'b1, 8'h10, 32'hDEADBEEF);
    load(1'b1, 8'h20, 32'h0);
    load(1'b1, 8'h30, 32'h0);
    load(1'b1, 8'h40, 32'h55AA55AA);
    for (int i = 0; i < 4; i++) load(1'b0, 8'h10 + 8'(i), 32'hB0000000 + 32'(i));
    cyc(); ld_a = 0; ld_b = 0;
    settle();
    check("rst_memRead",  {31'b0, ifa.memRead},  32'h0);
    check("rst_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    check("rst_dmaAck",   {31'b0, ifa.dmaAck},   32'h0);
    check("rst_dmaOut",   ifa.dmaOut,            32'h0);
    check("rst_pipeOut",  ifa.pipeOut,           32'h0);
    check("rst_b_pipeOut", ifb.pipeOut,          32'h0);
    cyc(); rst = 1'b1;

    // 1. Reset mid DMA write drops the access
    cyc(); ifa.dmaReq = 1; ifa.dmaWe = 1; ifa.dmaAddr = 32'h40; ifa.dmaData = 32'h12345678;
    settle();
    check("t1_c1_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    check("t1_c1_memAddr",  ifa.memAddr,           32'h40);
    cyc(); settle();
    check("t1_c2_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    rst = 1'b0; ifa.dmaReq = 0;
    settle();
    check("t1_rst_state",   {30'b0, dut_a.r_state}, 32'h0);
    check("t1_rst_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    cyc(); rst = 1'b1;
    settle();
    check("t1_rel_state",   {30'b0, dut_a.r_state}, 32'h0);
    check("t1_rel_dmaAck",  {31'b0, ifa.dmaAck},    32'h0);
    cyc(); settle();
    check("t1_mem40",       memA[8'h40],            32'h55AA55AA);
    check("t1_writes",      32'(wr_a),              32'h0);
    check("t1_dmaAck2",     {31'b0, ifa.dmaAck},    32'h0);

    // 2. Pipe load
    cyc(); ifa.pipeRead = 1; ifa.pipeAddr = 32'h10;
    settle(); check("t2_c1_stall", {31'b0, ifa.pipeStall}, 32'h1);
    cyc(); settle(); check("t2_c2_stall", {31'b0, ifa.pipeStall}, 32'h1);
    cyc(); settle();
    check("t2_c3_stall",   {31'b0, ifa.pipeStall}, 32'h0);
    check("t2_c3_pipeOut", ifa.pipeOut,            32'hDEADBEEF);
    cyc(); ifa.pipeRead = 0; ifa.pipeAddr = 32'h0;
    settle(); check("t2_held_pipeOut", ifa.pipeOut, 32'hDEADBEEF);

    // 3. Pipe store then DMA read-back
    cyc(); ifa.pipeWrite = 1; ifa.pipeAddr = 32'h20; ifa.pipeData = 32'h00001234;
    settle(); check("t3_c1_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    cyc(); settle(); check("t3_c2_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    cyc(); settle();
    check("t3_c3_memWrite", {31'b0, ifa.memWrite}, 32'h1);
    check("t3_c3_stall",    {31'b0, ifa.pipeStall}, 32'h0);
    cyc(); ifa.pipeWrite = 0; ifa.dmaReq = 1; ifa.dmaWe = 0; ifa.dmaAddr = 32'h20;
    settle();
    check("t3_mem20",       memA[8'h20],           32'h00001234);
    check("t3_d1_memRead",  {31'b0, ifa.memRead},  32'h1);
    check("t3_d1_memWrite", {31'b0, ifa.memWrite}, 32'h0);
    cyc(); cyc(); settle();
    check("t3_d3_dmaAck",   {31'b0, ifa.dmaAck},   32'h0);
    cyc(); settle();
    check("t3_ack",         {31'b0, ifa.dmaAck},   32'h1);
    check("t3_dmaOut",      ifa.dmaOut,            32'h00001234);
    ifa.dmaReq = 0;
    cyc(); settle();
    check("t3_ack_end",     {31'b0, ifa.dmaAck},   32'h0);
    check("t3_dmaOut_held", ifa.dmaOut,            32'h00001234);

    // 4. Starvation limit with back-to-back pipe loads
    cyc(); ifa.pipeRead = 1; ifa.pipeAddr = 32'h10;
    ifa.dmaReq = 1; ifa.dmaWe = 0; ifa.dmaAddr = 32'h40;
    settle();
    check("t4_k1_stall",   {31'b0, ifa.pipeStall}, 32'h1);
    check("t4_k1_addr",    ifa.memAddr,            32'h10);
    cyc(); settle(); check("t4_k2_starve", {30'b0, dut_a.r_starve}, 32'h1);
    cyc(); settle(); check("t4_k3_stall", {31'b0, ifa.pipeStall}, 32'h0);
    cyc(); settle(); check("t4_k4_addr", ifa.memAddr, 32'h10);
    cyc(); settle(); check("t4_k5_starve", {30'b0, dut_a.r_starve}, 32'h2);
    cyc(); settle(); check("t4_k6_stall", {31'b0, ifa.pipeStall}, 32'h0);
    cyc(); settle();
    check("t4_k7_addr",    ifa.memAddr,            32'h40);
    check("t4_k7_memRead", {31'b0, ifa.memRead},   32'h1);
    check("t4_k7_stall",   {31'b0, ifa.pipeStall}, 32'h1);
    cyc(); settle(); check("t4_k8_starve", {30'b0, dut_a.r_starve}, 32'h0);
    cyc(); settle(); check("t4_k9_dmaAck", {31'b0, ifa.dmaAck}, 32'h0);
    cyc(); settle();
    check("t4_k10_dmaAck", {31'b0, ifa.dmaAck},    32'h1);
    check("t4_k10_dmaOut", ifa.dmaOut,             32'h55AA55AA);
    check("t4_k10_addr",   ifa.memAddr,            32'h10);
    ifa.dmaReq = 0;
    cyc(); settle();
    check("t4_k11_dmaAck", {31'b0, ifa.dmaAck},    32'h0);
    check("t4_k11_starve", {30'b0, dut_a.r_starve}, 32'h0);
    cyc(); settle(); check("t4_k12_stall", {31'b0, ifa.pipeStall}, 32'h0);
    cyc(); ifa.pipeRead = 0;

    // 5. Single-cycle build: four consecutive loads, never stalled
    for (int i = 0; i < 4; i++) begin
      cyc(); ifb.pipeRead = 1; ifb.pipeAddr = 32'h10 + 32'(i);
      settle();
      check("t5_stall",   {31'b0, ifb.pipeStall}, 32'h0);
      check("t5_pipeOut", ifb.pipeOut,            32'hB0000000 + 32'(i));
    end
    cyc(); ifb.pipeRead = 0;
    settle(); check("t5_held", ifb.pipeOut, 32'hB0000003);

    // 6a. Read and write together behave as a write
    cyc(); ifa.pipeRead = 1; ifa.pipeWrite = 1; ifa.pipeAddr = 32'h30; ifa.pipeData = 32'hCAFEF00D;
    settle(); check("t6_c1_memRead", {31'b0, ifa.memRead}, 32'h0);
    cyc(); cyc(); settle(); check("t6_c3_memWrite", {31'b0, ifa.memWrite}, 32'h1);
    cyc(); ifa.pipeRead = 0; ifa.pipeWrite = 0;
    settle(); check("t6_mem30", memA[8'h30], 32'hCAFEF00D);

    // 6b. dmaReq dropped mid-read still completes and acks once
    cyc(); ifa.dmaReq = 1; ifa.dmaWe = 0; ifa.dmaAddr = 32'h30;
    settle(); check("t6_d1_memRead", {31'b0, ifa.memRead}, 32'h1);
    cyc(); ifa.dmaReq = 0;
    settle(); check("t6_d2_memRead", {31'b0, ifa.memRead}, 32'h1);
    cyc(); settle();
    check("t6_d3_memRead", {31'b0, ifa.memRead}, 32'h1);
    check("t6_d3_addr",    ifa.memAddr,          32'h30);
    cyc(); settle();
    check("t6_ack",        {31'b0, ifa.dmaAck},  32'h1);
    check("t6_dmaOut",     ifa.dmaOut,           32'hCAFEF00D);
    cyc(); settle(); check("t6_ack_end", {31'b0, ifa.dmaAck}, 32'h0);
    cyc(); settle(); check("t6_no_reack", {31'b0, ifa.dmaAck}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
